// File: rtl/mt_sequencer_param_if.sv
// Bus between the CPU control logic and the parametrised M/T sequencer.
// The control logic holds the master side; the sequencer holds the slave side.
interface mt_sequencer_param_if #(
  parameter int NUM_M    = 6,
  parameter int NUM_T    = 6,
  parameter int NUM_HOLD = 3
);

  localparam int MW = $clog2(NUM_M);
  localparam int TW = $clog2(NUM_T);

  logic                nextM;
  logic                setM1;
  logic [NUM_HOLD-1:0] hold;
  logic                clr_err;
  logic [NUM_M-1:0]    m_onehot;
  logic [NUM_T-1:0]    t_onehot;
  logic [MW-1:0]       m_idx;
  logic [TW-1:0]       t_idx;
  logic                timings_en;
  logic                seq_err;

  modport master (
    output nextM, setM1, hold, clr_err,
    input  m_onehot, t_onehot, m_idx, t_idx, timings_en, seq_err
  );

  modport slave (
    input  nextM, setM1, hold, clr_err,
    output m_onehot, t_onehot, m_idx, t_idx, timings_en, seq_err
  );

endinterface

// File: rtl/mt_sequencer_param.sv
// Parametrised machine-cycle / T-state sequencer with configurable hold masking,
// optional M wrap-around and a sticky sequencing-error flag.
module mt_sequencer_param #(
  parameter int                  NUM_M     = 6,
  parameter int                  NUM_T     = 6,
  parameter int                  NUM_HOLD  = 3,
  parameter logic [NUM_HOLD-1:0] HOLD_MASK = {NUM_HOLD{1'b1}},
  parameter bit                  WRAP_M    = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  mt_sequencer_param_if.slave bus
);

  localparam int MW = $clog2(NUM_M);
  localparam int TW = $clog2(NUM_T);

  localparam logic [MW-1:0]    LAST_M = MW'(NUM_M - 1);
  localparam logic [TW-1:0]    LAST_T = TW'(NUM_T - 1);
  localparam logic [NUM_M-1:0] M_ONE  = NUM_M'(1);
  localparam logic [NUM_T-1:0] T_ONE  = NUM_T'(1);

  if (NUM_M < 2) begin : gBadNumM
    $error("mt_sequencer_param: NUM_M must be >= 2");
  end
  if (NUM_T < 3) begin : gBadNumT
    $error("mt_sequencer_param: NUM_T must be >= 3");
  end
  if (NUM_HOLD < 1) begin : gBadNumHold
    $error("mt_sequencer_param: NUM_HOLD must be >= 1");
  end

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RESTART,
    ACT_NEXT_M,
    ACT_WRAP,
    ACT_M_ERR,
    ACT_STEP_T,
    ACT_OVERRUN
  } action_e;

  logic [MW-1:0]    mIdx_q, mIdx_d;
  logic [TW-1:0]    tIdx_q, tIdx_d;
  logic [NUM_M-1:0] mOnehot_q, mOnehot_d;
  logic [NUM_T-1:0] tOnehot_q, tOnehot_d;
  logic             timingsEn_q, timingsEn_d;
  logic             seqErr_q, seqErr_d;
  logic             holdEff;
  logic             errEvent;
  action_e          action;

  assign holdEff = |(bus.hold & HOLD_MASK);

  // Priority decode of what the sequencer does on the coming edge.
  always_comb begin
    action = ACT_HOLD;
    if (!holdEff) begin
      if (bus.setM1) begin
        action = ACT_RESTART;
      end else if (bus.nextM) begin
        if (mIdx_q != LAST_M) begin
          action = ACT_NEXT_M;
        end else if (WRAP_M) begin
          action = ACT_WRAP;
        end else begin
          action = ACT_M_ERR;
        end
      end else if (tIdx_q != LAST_T) begin
        action = ACT_STEP_T;
      end else begin
        action = ACT_OVERRUN;
      end
    end
  end

  always_comb begin
    mIdx_d   = mIdx_q;
    tIdx_d   = tIdx_q;
    errEvent = 1'b0;
    case (action)
      ACT_RESTART: begin
        mIdx_d = '0;
        tIdx_d = '0;
      end
      ACT_NEXT_M: begin
        mIdx_d = mIdx_q + MW'(1);
        tIdx_d = '0;
      end
      ACT_WRAP: begin
        mIdx_d = '0;
        tIdx_d = '0;
      end
      ACT_M_ERR:   errEvent = 1'b1;
      ACT_STEP_T:  tIdx_d = tIdx_q + TW'(1);
      ACT_OVERRUN: errEvent = 1'b1;
      default: begin
        mIdx_d = mIdx_q;
        tIdx_d = tIdx_q;
      end
    endcase

    // A fresh error outranks a simultaneous clear; clearing works even while held.
    seqErr_d    = errEvent | (seqErr_q & ~bus.clr_err);
    timingsEn_d = ~holdEff;
    mOnehot_d   = M_ONE << mIdx_d;
    tOnehot_d   = T_ONE << tIdx_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mIdx_q      <= '0;
      tIdx_q      <= '0;
      mOnehot_q   <= M_ONE;
      tOnehot_q   <= T_ONE;
      timingsEn_q <= 1'b0;
      seqErr_q    <= 1'b0;
    end else begin
      mIdx_q      <= mIdx_d;
      tIdx_q      <= tIdx_d;
      mOnehot_q   <= mOnehot_d;
      tOnehot_q   <= tOnehot_d;
      timingsEn_q <= timingsEn_d;
      seqErr_q    <= seqErr_d;
    end
  end

  assign bus.m_idx      = mIdx_q;
  assign bus.t_idx      = tIdx_q;
  assign bus.m_onehot   = mOnehot_q;
  assign bus.t_onehot   = tOnehot_q;
  assign bus.timings_en = timingsEn_q;
  assign bus.seq_err    = seqErr_q;

endmodule

// File: tb/tb_mt_sequencer_param.sv
// Bench for mt_sequencer_param: three differently configured instances driven
// side by side and compared every cycle against a counter-level reference model.
module tb_mt_sequencer_param;

  localparam int NI = 3;

  logic clk;
  logic reset;

  logic       nxt [NI];
  logic       s1  [NI];
  logic [2:0] hld [NI];
  logic       clr [NI];

  int cfgNumM [NI] = '{6, 4, 3};
  int cfgNumT [NI] = '{6, 6, 4};
  int cfgMask [NI] = '{7, 5, 7};
  int cfgWrap [NI] = '{1, 0, 1};

  int mM   [NI];
  int mT   [NI];
  int mErr [NI];
  int mTen [NI];

  int nCompared;
  int nMismatched;

  mt_sequencer_param_if #(.NUM_M(6), .NUM_T(6), .NUM_HOLD(3)) if0 ();
  mt_sequencer_param_if #(.NUM_M(4), .NUM_T(6), .NUM_HOLD(3)) if1 ();
  mt_sequencer_param_if #(.NUM_M(3), .NUM_T(4), .NUM_HOLD(3)) if2 ();

  mt_sequencer_param #(.NUM_M(6), .NUM_T(6), .NUM_HOLD(3)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  mt_sequencer_param #(.NUM_M(4), .NUM_T(6), .NUM_HOLD(3),
                       .HOLD_MASK(3'b101), .WRAP_M(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );
  mt_sequencer_param #(.NUM_M(3), .NUM_T(4), .NUM_HOLD(3)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave)
  );

  assign if0.nextM = nxt[0];  assign if0.setM1 = s1[0];
  assign if0.hold  = hld[0];  assign if0.clr_err = clr[0];
  assign if1.nextM = nxt[1];  assign if1.setM1 = s1[1];
  assign if1.hold  = hld[1];  assign if1.clr_err = clr[1];
  assign if2.nextM = nxt[2];  assign if2.setM1 = s1[2];
  assign if2.hold  = hld[2];  assign if2.clr_err = clr[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkInst(int i, logic [31:0] mi, logic [31:0] ti, logic [31:0] mo,
                           logic [31:0] to, logic [31:0] te, logic [31:0] se);
    check($sformatf("i%0d_m_idx", i), mi, 32'(mM[i]));
    check($sformatf("i%0d_t_idx", i), ti, 32'(mT[i]));
    check($sformatf("i%0d_m_onehot", i), mo, 32'(1) << mM[i]);
    check($sformatf("i%0d_t_onehot", i), to, 32'(1) << mT[i]);
    check($sformatf("i%0d_timings_en", i), te, 32'(mTen[i]));
    check($sformatf("i%0d_seq_err", i), se, 32'(mErr[i]));
  endtask

  task automatic checkOutput();
    checkInst(0, 32'(if0.m_idx), 32'(if0.t_idx), 32'(if0.m_onehot),
              32'(if0.t_onehot), 32'(if0.timings_en), 32'(if0.seq_err));
    checkInst(1, 32'(if1.m_idx), 32'(if1.t_idx), 32'(if1.m_onehot),
              32'(if1.t_onehot), 32'(if1.timings_en), 32'(if1.seq_err));
    checkInst(2, 32'(if2.m_idx), 32'(if2.t_idx), 32'(if2.m_onehot),
              32'(if2.t_onehot), 32'(if2.timings_en), 32'(if2.seq_err));
  endtask

  // Reference behaviour expressed directly on machine-cycle / T-state numbers.
  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      mM[i] = 0; mT[i] = 0; mErr[i] = 0; mTen[i] = 0;
    end
  endtask

  task automatic modelStep();
    for (int i = 0; i < NI; i++) begin
      bit held;
      bit errNow;
      held   = (int'(hld[i]) & cfgMask[i]) != 0;
      errNow = 0;
      if (!held) begin
        if (s1[i]) begin
          mM[i] = 0; mT[i] = 0;
        end else if (nxt[i]) begin
          if (mM[i] < cfgNumM[i] - 1) begin
            mM[i] = mM[i] + 1; mT[i] = 0;
          end else if (cfgWrap[i] == 1) begin
            mM[i] = 0; mT[i] = 0;
          end else begin
            errNow = 1;
          end
        end else if (mT[i] < cfgNumT[i] - 1) begin
          mT[i] = mT[i] + 1;
        end else begin
          errNow = 1;
        end
      end
      if (errNow) mErr[i] = 1;
      else if (clr[i]) mErr[i] = 0;
      mTen[i] = held ? 0 : 1;
    end
  endtask

  // mode 0 idle, 1 normal M1..Mlast sequencing, 2 random, 3 nextM at every last T
  task automatic applyStimulus(int mode);
    for (int i = 0; i < NI; i++) begin
      bit atLastT;
      atLastT = (mT[i] == cfgNumT[i] - 1);
      nxt[i] = 1'b0; s1[i] = 1'b0; hld[i] = 3'b000; clr[i] = 1'b0;
      case (mode)
        1: begin
          nxt[i] = atLastT && (mM[i] < cfgNumM[i] - 1);
          s1[i]  = atLastT && (mM[i] == cfgNumM[i] - 1);
        end
        2: begin
          nxt[i] = ($urandom_range(0, 3) == 0);
          s1[i]  = ($urandom_range(0, 15) == 0);
          hld[i] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
          clr[i] = ($urandom_range(0, 9) == 0);
        end
        3: nxt[i] = atLastT;
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1 checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(0);
    reset = 1'b1;
    #2 modelReset();
    checkOutput();
    @(posedge clk);
    #1 checkOutput();
    #3 reset = 1'b0;
  endtask

  task automatic timeoutFail(string tag);
    nCompared++;
    nMismatched++;
    $error("[TB] FAIL %s observed=timeout expected=reached", tag);
  endtask

  initial begin
    int budget;
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b1;
    applyStimulus(0);

    $display("[TB] reset and normal M/T sequencing");
    doReset();
    for (int k = 0; k < 80; k++) begin
      applyStimulus(1);
      cycle();
    end

    $display("[TB] free-run overrun and clr_err");
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0);
      cycle();
    end
    applyStimulus(0);
    for (int i = 0; i < NI; i++) clr[i] = 1'b1;
    cycle();

    $display("[TB] hold at M2 T3 with nextM pending");
    doReset();
    budget = 0;
    while (!(mM[0] == 1 && mT[0] == 2) && budget < 50) begin
      applyStimulus(1);
      cycle();
      budget++;
    end
    if (budget >= 50) timeoutFail("steer_m2t3");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0);
      for (int i = 0; i < NI; i++) begin
        hld[i] = 3'b010;
        nxt[i] = 1'b1;
      end
      cycle();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0);
      cycle();
    end

    $display("[TB] nextM at last M without wrap, then clr_err with nextM");
    doReset();
    for (int k = 0; k < 30; k++) begin
      applyStimulus(3);
      cycle();
    end
    applyStimulus(0);
    for (int i = 0; i < NI; i++) begin
      nxt[i] = 1'b1;
      clr[i] = 1'b1;
    end
    cycle();
    applyStimulus(0);
    for (int i = 0; i < NI; i++) clr[i] = 1'b1;
    hld[1] = 3'b001;
    cycle();

    $display("[TB] asynchronous reset in the middle of a cycle");
    doReset();
    budget = 0;
    while (!(mM[2] == 1 && mT[2] == 2) && budget < 50) begin
      applyStimulus(1);
      cycle();
      budget++;
    end
    if (budget >= 50) timeoutFail("steer_i2_m2t3");
    @(posedge clk);
    modelStep();
    applyStimulus(0);
    #3 reset = 1'b1;
    #1 modelReset();
    checkOutput();
    #2 reset = 1'b0;
    #1 checkOutput();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1);
      cycle();
    end

    $display("[TB] randomized traffic");
    for (int k = 0; k < 600; k++) begin
      applyStimulus(2);
      cycle();
      if ($urandom_range(0, 99) == 0) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
